// File: rtl/aoi22_cut_checker.sv
// Self-test engine for an AOI22 cell-under-test: walks all 16 {A,B,C,D} vectors,
// samples Y after a settle window and compares it with !((A&B)|(C&D)).
module aoi22_cut_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             cut_a,
  output logic             cut_b,
  output logic             cut_c,
  output logic             cut_d,
  input  logic             cut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [3:0]       fail_vec
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LOOPS_LAST  = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  function automatic logic golden_y(input logic [3:0] v);
    return ~((v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == ERR_MAX) begin
      return v;
    end else begin
      return v + ERR_W'(1'b1);
    end
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       vec_r, vec_s;
  logic [7:0]       loop_r, loop_s;
  logic [3:0]       settle_r, settle_s;
  logic [3:0]       drv_r, drv_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic             fail_valid_r, fail_valid_s;
  logic [3:0]       fail_vec_r, fail_vec_s;
  logic             mismatch_s;

  // Next-state, counter and result logic; outputs are derived from the next state so they stay registered.
  always_comb begin
    state_s      = state_r;
    vec_s        = vec_r;
    loop_s       = loop_r;
    settle_s     = settle_r;
    drv_s        = drv_r;
    done_s       = 1'b0;
    pass_s       = pass_r;
    err_s        = err_r;
    fail_valid_s = fail_valid_r;
    fail_vec_s   = fail_vec_r;
    mismatch_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s      = ST_DRIVE;
          vec_s        = 4'd0;
          loop_s       = 8'd0;
          pass_s       = 1'b0;
          err_s        = {ERR_W{1'b0}};
          fail_valid_s = 1'b0;
          fail_vec_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          state_s = ST_IDLE;
          drv_s   = 4'd0;
        end else begin
          state_s  = ST_SETTLE;
          drv_s    = vec_r;
          settle_s = 4'd0;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_s = ST_IDLE;
          drv_s   = 4'd0;
        end else if (settle_r == SETTLE_LAST) begin
          state_s = ST_SAMPLE;
        end else begin
          settle_s = settle_r + 4'd1;
        end
      end

      ST_SAMPLE: begin
        // A mismatch is recorded even when abort arrives in the same cycle.
        mismatch_s = (cut_y != golden_y(vec_r));
        if (mismatch_s) begin
          err_s = sat_inc(err_r);
          if (!fail_valid_r) begin
            fail_valid_s = 1'b1;
            fail_vec_s   = vec_r;
          end else begin
            fail_vec_s = fail_vec_r;
          end
        end else begin
          err_s = err_r;
        end

        if (abort) begin
          state_s = ST_IDLE;
          drv_s   = 4'd0;
        end else if (vec_r == 4'd15) begin
          vec_s  = 4'd0;
          loop_s = loop_r + 8'd1;
          if (loop_r == LOOPS_LAST) begin
            state_s = ST_DONE;
            drv_s   = 4'd0;
            done_s  = 1'b1;
            pass_s  = (err_s == {ERR_W{1'b0}});
          end else begin
            state_s = ST_DRIVE;
          end
        end else begin
          vec_s   = vec_r + 4'd1;
          state_s = ST_DRIVE;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
        drv_s   = 4'd0;
      end

      default: begin
        state_s = ST_IDLE;
        drv_s   = 4'd0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; rst_n is synchronous and dominates every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      vec_r        <= 4'd0;
      loop_r       <= 8'd0;
      settle_r     <= 4'd0;
      drv_r        <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_r        <= {ERR_W{1'b0}};
      fail_valid_r <= 1'b0;
      fail_vec_r   <= 4'd0;
    end else begin
      state_r      <= state_s;
      vec_r        <= vec_s;
      loop_r       <= loop_s;
      settle_r     <= settle_s;
      drv_r        <= drv_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      err_r        <= err_s;
      fail_valid_r <= fail_valid_s;
      fail_vec_r   <= fail_vec_s;
    end
  end

  assign cut_a      = drv_r[3];
  assign cut_b      = drv_r[2];
  assign cut_c      = drv_r[1];
  assign cut_d      = drv_r[0];
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign fail_valid = fail_valid_r;
  assign fail_vec   = fail_vec_r;

endmodule

// File: tb/tb_aoi22_cut_checker.sv
// Directed bench for aoi22_cut_checker: ideal, stuck-at, delayed CUT models,
// abort, mid-run reset and held start, against hand-computed results.
module tb_aoi22_cut_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic [3:0] start_v = 4'd0;
  logic y_stuck1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic aoi(input logic [3:0] v);
    return ~((v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  // Instance 0: defaults, ideal or stuck-at-1 CUT
  logic [3:0] drv0, fvec0;
  logic [7:0] err0;
  logic busy0, done0, pass0, fv0, y0;
  assign y0 = y_stuck1 ? 1'b1 : aoi(drv0);
  aoi22_cut_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
    .cut_a(drv0[3]), .cut_b(drv0[2]), .cut_c(drv0[1]), .cut_d(drv0[0]),
    .cut_y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0));

  // Instance 1: ERR_W=3, LOOPS=2, stuck-at-0 CUT
  logic [3:0] drv1, fvec1;
  logic [2:0] err1;
  logic busy1, done1, pass1, fv1;
  aoi22_cut_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(1'b0),
    .cut_a(drv1[3]), .cut_b(drv1[2]), .cut_c(drv1[1]), .cut_d(drv1[0]),
    .cut_y(1'b0), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1));

  // Instances 2/3: CUT whose Y lags its inputs by two cycles
  logic [3:0] drv2, fvec2, drv3, fvec3;
  logic [7:0] err2, err3;
  logic busy2, done2, pass2, fv2, busy3, done3, pass3, fv3;
  logic s1_d1 = 1'b1, s1_d2 = 1'b1, s3_d1 = 1'b1, s3_d2 = 1'b1;
  always @(posedge clk) begin
    s1_d1 <= aoi(drv2);
    s1_d2 <= s1_d1;
    s3_d1 <= aoi(drv3);
    s3_d2 <= s3_d1;
  end
  aoi22_cut_checker #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(1'b0),
    .cut_a(drv2[3]), .cut_b(drv2[2]), .cut_c(drv2[1]), .cut_d(drv2[0]),
    .cut_y(s1_d2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2));
  aoi22_cut_checker #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(1'b0),
    .cut_a(drv3[3]), .cut_b(drv3[2]), .cut_c(drv3[1]), .cut_d(drv3[0]),
    .cut_y(s3_d2), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_valid(fv3), .fail_vec(fvec3));

  // Observation mux over the instance under test
  int sel = 0;
  logic [3:0] drv_m, fvec_m;
  logic [7:0] err_m;
  logic busy_m, done_m, pass_m, fv_m;
  always_comb begin
    drv_m = drv0; fvec_m = fvec0; err_m = err0;
    busy_m = busy0; done_m = done0; pass_m = pass0; fv_m = fv0;
    case (sel)
      1: begin drv_m = drv1; fvec_m = fvec1; err_m = {5'd0, err1};
               busy_m = busy1; done_m = done1; pass_m = pass1; fv_m = fv1; end
      2: begin drv_m = drv2; fvec_m = fvec2; err_m = err2;
               busy_m = busy2; done_m = done2; pass_m = pass2; fv_m = fv2; end
      3: begin drv_m = drv3; fvec_m = fvec3; err_m = err3;
               busy_m = busy3; done_m = done3; pass_m = pass3; fv_m = fv3; end
      default: begin end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [7:0] e_err, input logic e_fv,
                               input logic [3:0] e_fvec, input logic e_pass);
    check_eq({tag, "_err"}, err_m, e_err);
    check_eq({tag, "_fv"}, fv_m, e_fv);
    check_eq({tag, "_fvec"}, fvec_m, e_fvec);
    check_eq({tag, "_pass"}, pass_m, e_pass);
  endtask

  // Pulse start on instance idx and return the cycle index (DRIVE = 1) at which done is seen.
  task automatic run_wait(input int idx, input int budget, input bit chk_drv, output int cyc);
    sel = idx;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    cyc = 1;
    check_eq("busy_on_accept", busy_m, 1);
    while (!done_m && cyc < budget) begin
      if (chk_drv && cyc >= 2 && cyc <= 62 && ((cyc - 2) % 4) == 0)
        check_eq("drv_seq", drv_m, 32'((cyc - 2) / 4));
      @(negedge clk);
      cyc++;
    end
    if (!done_m) check_eq("done_timeout", done_m, 1);
  endtask

  task automatic wait_drv(input logic [3:0] v, input int budget);
    int n;
    n = 0;
    while (drv_m != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_drv", drv_m, v);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_drv"}, drv_m, 0);
    check_eq({tag, "_busy"}, busy_m, 0);
    check_eq({tag, "_done"}, done_m, 0);
    check_results(tag, 8'd0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int cyc;
    int n_done;

    repeat (3) @(negedge clk);
    sel = 0;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal CUT: 16 vectors x 4 cycles, DONE 64 cycles after first DRIVE
    run_wait(0, 200, 1'b1, cyc);
    check_eq("ideal_done_cyc", cyc, 65);
    check_results("ideal", 8'd0, 1'b0, 4'd0, 1'b1);
    check_eq("ideal_drv_done", drv_m, 0);
    @(negedge clk);
    check_eq("ideal_done_pulse", done_m, 0);
    check_eq("ideal_busy_off", busy_m, 0);

    // Stuck-at-1: the 7 vectors with A&B or C&D true fail, first is 0011
    y_stuck1 = 1'b1;
    run_wait(0, 200, 1'b0, cyc);
    check_results("stuck1", 8'd7, 1'b1, 4'b0011, 1'b0);
    y_stuck1 = 1'b0;
    @(negedge clk);

    // Stuck-at-0 over two loops: 18 raw mismatches saturate a 3-bit counter
    run_wait(1, 300, 1'b0, cyc);
    check_eq("sat_done_cyc", cyc, 129);
    check_results("sat", 8'd7, 1'b1, 4'b0000, 1'b0);
    @(negedge clk);

    // Lagging CUT, settle 1: Y shows previous vector; f changes at 3,4,7,8,11
    run_wait(2, 200, 1'b0, cyc);
    check_eq("lag1_done_cyc", cyc, 49);
    check_results("lag1", 8'd5, 1'b1, 4'b0011, 1'b0);
    @(negedge clk);

    // Lagging CUT, settle 3: 16 x 5 cycles, clean
    run_wait(3, 200, 1'b0, cyc);
    check_eq("lag3_done_cyc", cyc, 81);
    check_results("lag3", 8'd0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);

    // Abort at vec 5: no done, drives 0, then a normal run
    sel = 0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_drv(4'd5, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy_m, 0);
    check_eq("abort_drv", drv_m, 0);
    check_eq("abort_pass", pass_m, 0);
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_m) n_done++;
    end
    check_eq("abort_no_done", n_done, 0);
    run_wait(0, 200, 1'b0, cyc);
    check_eq("post_abort_cyc", cyc, 65);
    check_eq("post_abort_pass", pass_m, 1);
    @(negedge clk);

    // Reset mid-run at vec 9 with errors already counted
    y_stuck1 = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_drv(4'd9, 100);
    check_eq("pre_reset_err", err_m, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    rst_n = 1'b1;
    y_stuck1 = 1'b0;
    @(negedge clk);
    run_wait(0, 200, 1'b0, cyc);
    check_eq("post_reset_cyc", cyc, 65);
    check_results("post_reset", 8'd0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);

    // start held high: one run per IDLE visit, second run clears prior results
    y_stuck1 = 1'b1;
    start_v[0] = 1'b1;
    n_done = 0;
    cyc = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      cyc++;
      if (done_m) n_done++;
      if (cyc == 65) begin
        check_eq("held_done1", done_m, 1);
        check_results("held_run1", 8'd7, 1'b1, 4'b0011, 1'b0);
      end
      if (cyc == 66) begin
        check_eq("held_idle_busy", busy_m, 0);
        y_stuck1 = 1'b0;
      end
      if (cyc == 67) begin
        check_eq("held_restart_busy", busy_m, 1);
        check_eq("held_clear_err", err_m, 0);
        check_eq("held_clear_fv", fv_m, 0);
      end
      if (cyc == 131) begin
        check_eq("held_done2", done_m, 1);
        check_results("held_run2", 8'd0, 1'b0, 4'd0, 1'b1);
      end
    end
    start_v[0] = 1'b0;
    check_eq("held_done_count", n_done, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
